inst_fetch_port: RTL and testbench
==================================

// Module: inst_fetch_port
// PURPOSE
//  Memory-side partner of the IF stage. Accepts a word-fetch request (inst_req/inst_addr_i).
//  Reads 4 bytes over the byte-wide RAM port and assembles them little-endian.
//  Returns the word on inst_o and signals completion with inst_done, which IF uses as its stall source.
//  Sits between IF and the memory arbiter. Optional direct-mapped I-cache in front of the RAM port.
// PARAMETERS
//  ICACHE_LINES  64  number of one-word cache lines, power of 2 (used only with ICACHE_EN)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   reset, asynchronous, active-low (rst==0 resets immediately)
//  inst_req     in   1   fetch request from IF, sampled at rising edge
//  inst_addr_i  in   32  fetch byte address, word-aligned (addr[1:0]==0, not checked)
//  flush        in   1   abort in-flight fetch (branch redirect)
//  inst_o       out  32  fetched instruction, registered
//  inst_done    out  1   1 = idle/result valid; 0 = fetch in progress
//  mem_busy     in   1   arbiter: RAM port in use by data side, do not start
//  mem_rd       out  1   RAM read strobe, registered
//  mem_a        out  32  RAM byte address, registered
//  mem_din      in   8   RAM read data, valid the cycle after mem_a/mem_rd presented
// BEHAVIOUR
//  Reset: inst_o=0, inst_done=1, mem_rd=0, mem_a=0, FSM=IDLE, byte counter=0, cache valid bits=0.
//  FSM states: IDLE, READ.
//  IDLE, inst_req=1, mem_busy=0 at edge T: latch addr; mem_a<=addr; mem_rd<=1; inst_done<=0; go READ.
//  IDLE, inst_req=1, mem_busy=1: not accepted, FSM stays IDLE; IF must hold inst_req until accepted.
//  READ, issue side: edges T+1..T+3 drive mem_a<=addr+1..addr+3; mem_rd<=0 at edge T+4.
//  READ, capture side: edges T+2..T+5 capture mem_din into bytes 0..3. Byte k goes to word[8k+7:8k].
//  Completion at edge T+5: inst_o<=assembled word; inst_done<=1; go IDLE.
//    Miss latency = 5 cycles from the accept edge.
//  Once in READ the port owns the RAM bus; mem_busy is ignored until return to IDLE.
//  inst_req during READ: ignored. No queueing.
//  Address arithmetic: addr+k is computed modulo 2^32, so 0xFFFFFFFE wraps to 0x00000000.
//  flush=1 in READ: abort at that edge. mem_rd<=0, FSM<=IDLE, inst_done<=1, inst_o unchanged.
//    Bytes still returning from RAM are discarded; no cache fill.
//  flush=1 in IDLE: no effect; a simultaneous inst_req is accepted normally.
//  Async reset mid-READ: all state is reset immediately; the partial word is lost.
// CONFIGURATION
//  ICACHE_EN defined: direct-mapped cache with ICACHE_LINES lines.
//    index = addr[log2(ICACHE_LINES)+1:2]; tag = remaining upper bits; one valid bit per line.
//    Hit in IDLE at edge T: inst_o<=line data; inst_done stays 1; no RAM access (mem_busy ignored).
//      Hit latency = 1 cycle.
//    Miss: normal READ sequence; line is filled (valid=1) at the completion edge. A flushed miss does not fill.
//  ICACHE_EN undefined: no cache storage; every request takes the 5-cycle READ path.
// STRUCTURE
//  Shared defines file holds FSM state encodings and ICACHE tag/index width derivations.
//  The existing `True/`False/`Zero constants are reused.
//  Sub-module icache_dm (tag/valid/data arrays, lookup and fill port) is instantiated only under ICACHE_EN.
//  Top level holds the FSM, byte counter and assembly register.
// TESTING
//  1 Reset then idle: inst_done=1, mem_rd=0, inst_o=0.
//  2 Basic fetch: RAM[0x100..0x103]=13,05,00,00, req 0x100.
//    -> mem_a 0x100..0x103 on consecutive cycles; inst_o=0x00000513 and inst_done=1 at T+5.
//  3 Blocked start: req 0x200 with mem_busy=1 for 3 cycles, then 0.
//    -> accept on the first edge with mem_busy=0; no mem_rd before it.
//  4 Flush at T+3 of fetch 0x100: inst_done=1 next cycle; inst_o keeps its old value.
//    Next req 0x104 returns RAM[0x104..0x107] correctly.
//  5 Wrap: req 0xFFFFFFFE. -> mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
//  6 ICACHE_EN: fetch 0x100 twice. -> second returns the same word with inst_done never low and no mem_rd.
//    Then 0x100+4*ICACHE_LINES misses, evicts the line, and a refetch of 0x100 misses again.

Source files
------------

// File: rtl/inst_fetch_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_port_pkg
// Purpose  : Shared definitions for the instruction fetch port. Holds the
//            FSM state encoding, the common truth/zero constants and the
//            I-cache index/tag width derivations.
// Revision : 1.0  initial release
// ============================================================================
package inst_fetch_port_pkg;

   // Common constants
   localparam logic        c_TRUE   = 1'b1;
   localparam logic        c_FALSE  = 1'b0;
   localparam logic [31:0] c_ZERO32 = 32'h0000_0000;

   // Fetch FSM states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } fetch_state_t;

   // Word-index bits for a direct-mapped cache of one-word lines
   function automatic int icache_index_bits(input int lines);
      return $clog2(lines);
   endfunction

   // Tag bits left over once the byte offset (2) and index are removed
   function automatic int icache_tag_bits(input int lines);
      return 30 - $clog2(lines);
   endfunction

endpackage : inst_fetch_port_pkg
`default_nettype wire

// File: rtl/inst_fetch_port_icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm
// Purpose  : Direct-mapped instruction cache with one-word lines. Provides a
//            combinational lookup on a word address and a single fill port.
//            Only the valid bits are reset; tag and data arrays are qualified
//            by valid and need no reset.
// Revision : 1.0  initial release
// ============================================================================
module icache_dm
   import inst_fetch_port_pkg::*;
#(
   parameter int LINES = 64
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] i_lookup_wa,
   output logic        o_hit,
   output logic [31:0] o_data,
   input  logic        i_fill,
   input  logic [29:0] i_fill_wa,
   input  logic [31:0] i_fill_data
);

   localparam int c_IDX_W = icache_index_bits(LINES);
   localparam int c_TAG_W = icache_tag_bits(LINES);

   logic [LINES-1:0]   r_valid;
   logic [c_TAG_W-1:0] r_tag  [LINES];
   logic [31:0]        r_data [LINES];

   logic [c_IDX_W-1:0] w_lk_idx;
   logic [c_TAG_W-1:0] w_lk_tag;
   logic [c_IDX_W-1:0] w_fl_idx;
   logic [c_TAG_W-1:0] w_fl_tag;

   assign w_lk_idx = i_lookup_wa[c_IDX_W-1:0];
   assign w_lk_tag = i_lookup_wa[29:c_IDX_W];
   assign w_fl_idx = i_fill_wa[c_IDX_W-1:0];
   assign w_fl_tag = i_fill_wa[29:c_IDX_W];

   assign o_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign o_data = r_data[w_lk_idx];

   // Valid bits: cleared by reset, set when a line is filled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
      end else if (i_fill) begin
         r_valid[w_fl_idx] <= c_TRUE;
      end
   end

   // Tag and data storage written on fill
   always_ff @(posedge clk) begin
      if (i_fill) begin
         r_tag[w_fl_idx]  <= w_fl_tag;
         r_data[w_fl_idx] <= i_fill_data;
      end
   end

endmodule : icache_dm
`default_nettype wire

// File: rtl/inst_fetch_port.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_port
// Purpose  : Memory-side partner of the IF stage. Fetches a 32-bit word as
//            four byte reads over the byte-wide RAM port and assembles it
//            little-endian. inst_done is low while a fetch is in flight.
//            Define ICACHE_EN to place a direct-mapped I-cache (icache_dm,
//            ICACHE_LINES one-word lines) in front of the RAM port.
// Revision : 1.0  initial release
// ============================================================================
module inst_fetch_port
`ifdef ICACHE_EN
#(
   parameter int ICACHE_LINES = 64
)
`endif
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr_i,
   input  logic        flush,
   output logic [31:0] inst_o,
   output logic        inst_done,
   input  logic        mem_busy,
   output logic        mem_rd,
   output logic [31:0] mem_a,
   input  logic [7:0]  mem_din
);
   import inst_fetch_port_pkg::*;

   fetch_state_t r_state;
   logic [31:0]  r_addr;
   logic [2:0]   r_cnt;
   logic [23:0]  r_bytes;
   logic [31:0]  r_inst;
   logic         r_done;
   logic         r_rd;
   logic [31:0]  r_mem_a;

   logic         w_hit;
   logic [31:0]  w_hit_data;
   logic [31:0]  w_word;

   // Final byte arrives on mem_din in the completion cycle
   assign w_word = {mem_din, r_bytes};

`ifdef ICACHE_EN
   logic w_fill;

   // Fill only on an unflushed completion
   assign w_fill = (r_state == ST_READ) && !flush && (r_cnt == 3'd4);

   icache_dm #(
      .LINES       (ICACHE_LINES)
   ) u_icache (
      .clk         (clk),
      .rst         (rst),
      .i_lookup_wa (inst_addr_i[31:2]),
      .o_hit       (w_hit),
      .o_data      (w_hit_data),
      .i_fill      (w_fill),
      .i_fill_wa   (r_addr[31:2]),
      .i_fill_data (w_word)
   );
`else
   assign w_hit      = c_FALSE;
   assign w_hit_data = c_ZERO32;
`endif

   // Fetch FSM: accept in IDLE, issue four reads, capture four bytes, complete
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_addr  <= c_ZERO32;
         r_cnt   <= 3'd0;
         r_bytes <= 24'd0;
         r_inst  <= c_ZERO32;
         r_done  <= c_TRUE;
         r_rd    <= c_FALSE;
         r_mem_a <= c_ZERO32;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (inst_req) begin
                  if (w_hit) begin
                     // Cache hit: one-cycle return, RAM untouched
                     r_inst <= w_hit_data;
                  end else if (!mem_busy) begin
                     r_addr  <= inst_addr_i;
                     r_mem_a <= inst_addr_i;
                     r_rd    <= c_TRUE;
                     r_done  <= c_FALSE;
                     r_cnt   <= 3'd0;
                     r_state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (flush) begin
                  // Abort: discard in-flight bytes, keep the last result
                  r_rd    <= c_FALSE;
                  r_done  <= c_TRUE;
                  r_cnt   <= 3'd0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
                  case (r_cnt)
                     3'd0: begin
                        r_mem_a <= r_addr + 32'd1;
                     end
                     3'd1: begin
                        r_mem_a        <= r_addr + 32'd2;
                        r_bytes[7:0]   <= mem_din;
                     end
                     3'd2: begin
                        r_mem_a        <= r_addr + 32'd3;
                        r_bytes[15:8]  <= mem_din;
                     end
                     3'd3: begin
                        r_rd           <= c_FALSE;
                        r_bytes[23:16] <= mem_din;
                     end
                     default: begin
                        r_inst  <= w_word;
                        r_done  <= c_TRUE;
                        r_cnt   <= 3'd0;
                        r_state <= ST_IDLE;
                     end
                  endcase
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign inst_o    = r_inst;
   assign inst_done = r_done;
   assign mem_rd    = r_rd;
   assign mem_a     = r_mem_a;

endmodule : inst_fetch_port
`default_nettype wire

// File: tb/tb_inst_fetch_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_port
// Purpose  : Self-checking bench for inst_fetch_port with a byte-wide RAM
//            model answering one cycle after each read strobe.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr_i;
   logic        flush;
   logic [31:0] inst_o;
   logic        inst_done;
   logic        mem_busy;
   logic        mem_rd;
   logic [31:0] mem_a;
   logic [7:0]  mem_din;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] addr;
      int          busy;        // cycles mem_busy is held high before release
      int          flush_at;    // flush sampled at edge T+flush_at, 0 = none
      bit          flush_idle;  // flush held high on the accept edge
      logic [31:0] exp;         // inst_o after completion (or kept value)
   } vec_t;

   inst_fetch_port dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .inst_addr_i (inst_addr_i),
      .flush       (flush),
      .inst_o      (inst_o),
      .inst_done   (inst_done),
      .mem_busy    (mem_busy),
      .mem_rd      (mem_rd),
      .mem_a       (mem_a),
      .mem_din     (mem_din)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 8'h13;
         32'h0000_0101: return 8'h05;
         32'h0000_0102: return 8'h00;
         32'h0000_0103: return 8'h00;
         32'h0000_0104: return 8'h93;
         32'h0000_0105: return 8'h05;
         32'h0000_0106: return 8'h10;
         32'h0000_0107: return 8'h00;
         32'h0000_0200: return 8'h37;
         32'h0000_0201: return 8'h12;
         32'h0000_0202: return 8'h00;
         32'h0000_0203: return 8'h00;
         32'h0000_0300: return 8'h01;
         32'h0000_0301: return 8'h02;
         32'h0000_0302: return 8'h03;
         32'h0000_0303: return 8'h04;
         32'hFFFF_FFFE: return 8'hAA;
         32'hFFFF_FFFF: return 8'hBB;
         32'h0000_0000: return 8'hCC;
         32'h0000_0001: return 8'hDD;
         default:       return 8'hEE;
      endcase
   endfunction

   // RAM: data for a strobed address appears in the following cycle
   always @(posedge clk) begin
      if (mem_rd) mem_din <= ram_byte(mem_a);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      bit aborted;
      aborted = 1'b0;
      @(negedge clk);
      inst_addr_i = v.addr;
      inst_req    = 1'b1;
      mem_busy    = (v.busy > 0);
      flush       = v.flush_idle;
      for (int i = 0; i < v.busy; i++) begin
         @(negedge clk);
         check({v.name, " blocked mem_rd"},    32'(mem_rd),    32'd0);
         check({v.name, " blocked inst_done"}, 32'(inst_done), 32'd1);
      end
      mem_busy = 1'b0;
      @(negedge clk);
      inst_req = 1'b0;
      flush    = 1'b0;
      check({v.name, " accept mem_rd"},    32'(mem_rd),    32'd1);
      check({v.name, " accept inst_done"}, 32'(inst_done), 32'd0);
      check({v.name, " accept mem_a"},     mem_a,          v.addr);
      for (int k = 1; k <= 5 && !aborted; k++) begin
         if (v.flush_at == k) flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         if (v.flush_at == k) begin
            aborted = 1'b1;
            check({v.name, " flush mem_rd"},    32'(mem_rd),    32'd0);
            check({v.name, " flush inst_done"}, 32'(inst_done), 32'd1);
            check({v.name, " flush inst_o"},    inst_o,         v.exp);
         end else if (k <= 3) begin
            check($sformatf("%s mem_a+%0d", v.name, k), mem_a, v.addr + 32'(k));
            check($sformatf("%s mem_rd+%0d", v.name, k), 32'(mem_rd), 32'd1);
            check($sformatf("%s busy+%0d", v.name, k), 32'(inst_done), 32'd0);
         end else if (k == 4) begin
            check({v.name, " mem_rd drop"},  32'(mem_rd),    32'd0);
            check({v.name, " busy+4"},       32'(inst_done), 32'd0);
         end else begin
            check({v.name, " done"},   32'(inst_done), 32'd1);
            check({v.name, " inst_o"}, inst_o,         v.exp);
         end
      end
   endtask

`ifdef ICACHE_EN
   task automatic cache_hit(input string name, input logic [31:0] addr, input logic [31:0] exp);
      @(negedge clk);
      inst_addr_i = addr;
      inst_req    = 1'b1;
      mem_busy    = 1'b1;
      @(negedge clk);
      inst_req = 1'b0;
      mem_busy = 1'b0;
      check({name, " hit inst_done"}, 32'(inst_done), 32'd1);
      check({name, " hit mem_rd"},    32'(mem_rd),    32'd0);
      check({name, " hit inst_o"},    inst_o,         exp);
   endtask
`endif

   initial begin
      vec_t vecs[7];
      vec_t v;
      vecs[0] = '{"basic_100",   32'h0000_0100, 0, 0, 1'b0, 32'h0000_0513};
      vecs[1] = '{"blocked_200", 32'h0000_0200, 3, 0, 1'b0, 32'h0000_1237};
      vecs[2] = '{"flush_100",   32'h0000_0100, 0, 3, 1'b0, 32'h0000_1237};
      vecs[3] = '{"after_104",   32'h0000_0104, 0, 0, 1'b0, 32'h0010_0593};
      vecs[4] = '{"wrap",        32'hFFFF_FFFE, 0, 0, 1'b0, 32'hDDCC_BBAA};
      vecs[5] = '{"idleflush",   32'h0000_0300, 0, 0, 1'b1, 32'h0403_0201};
      vecs[6] = '{"flush_last",  32'h0000_0100, 0, 5, 1'b0, 32'h0403_0201};

      rst         = 1'b0;
      inst_req    = 1'b0;
      inst_addr_i = 32'd0;
      flush       = 1'b0;
      mem_busy    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset inst_o",    inst_o,         32'd0);
      check("reset inst_done", 32'(inst_done), 32'd1);
      check("reset mem_rd",    32'(mem_rd),    32'd0);
      check("reset mem_a",     mem_a,          32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle inst_done", 32'(inst_done), 32'd1);
      check("idle mem_rd",    32'(mem_rd),    32'd0);

      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         run_vec(v);
      end

      // Asynchronous reset in the middle of a fetch
      @(negedge clk);
      inst_addr_i = 32'h0000_0300;
      inst_req    = 1'b1;
      @(negedge clk);
      inst_req = 1'b0;
      check("arst started", 32'(inst_done), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst inst_done", 32'(inst_done), 32'd1);
      check("arst mem_rd",    32'(mem_rd),    32'd0);
      check("arst inst_o",    inst_o,         32'd0);
      check("arst mem_a",     mem_a,          32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("arst idle", 32'(inst_done), 32'd1);
      v = '{"post_arst_104", 32'h0000_0104, 0, 0, 1'b0, 32'h0010_0593};
      run_vec(v);

`ifdef ICACHE_EN
      v = '{"c_miss_100", 32'h0000_0100, 0, 0, 1'b0, 32'h0000_0513};
      run_vec(v);
      cache_hit("c_104", 32'h0000_0104, 32'h0010_0593);
      cache_hit("c_100", 32'h0000_0100, 32'h0000_0513);
      v = '{"c_evict", 32'h0000_0100 + 32'd4 * 32'd64, 0, 0, 1'b0, 32'h0000_1237};
      run_vec(v);
      v = '{"c_remiss_100", 32'h0000_0100, 0, 0, 1'b0, 32'h0000_0513};
      run_vec(v);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_inst_fetch_port
`default_nettype wire
